// File: rtl/gci_irq_pkg.sv
// Shared constants for the GCI node interrupt requester:
// FSM state encodings and register widths.
package gci_irq_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam int PRIO_W = 8;
    localparam int LOST_W = 8;

endpackage

// File: rtl/gci_sat_counter.sv
// Saturating up-counter with asynchronous active-low reset;
// sticks at all ones once reached.
module gci_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gci_node_irq_req.sv
// Node-side interrupt requester: sticky pending events, level IRQ
// toward the aggregator, cause capture on ACK, priority and lost count.
module gci_node_irq_req
    import gci_irq_pkg::*;
#(
    parameter int                P_EVENTS        = 4,
    parameter logic [PRIO_W-1:0] P_PRIORITY_INIT = 8'h00
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic [P_EVENTS-1:0] iEVENT,
    input  logic [P_EVENTS-1:0] iEVENT_MASK,
    input  logic                iPRIORITY_SET_REQ,
    input  logic [PRIO_W-1:0]   iPRIORITY_SET_DATA,
    output logic [PRIO_W-1:0]   oNODEINFO_PRIORITY,
    input  logic                iIRQ_BUSY,
    output logic                oIRQ,
    input  logic                iACK,
    output logic                oCAUSE_VALID,
    output logic [P_EVENTS-1:0] oCAUSE,
    input  logic                iCAUSE_CLEAR,
    output logic [LOST_W-1:0]   oLOST_COUNT
);

    logic [1:0]          state_q, state_d;
    logic [P_EVENTS-1:0] pend_q, pend_d;
    logic [P_EVENTS-1:0] cause_q, cause_d;
    logic                cv_q, cv_d;
    logic [PRIO_W-1:0]   prio_q, prio_d;

    logic                ack_ok;
    logic                clr_ok;
    logic [P_EVENTS-1:0] ev_en;
    logic [P_EVENTS-1:0] clr_mask;
    logic                lost_hit;

    assign ack_ok   = (state_q == ST_REQ) && iACK;
    assign clr_ok   = (state_q == ST_SERVICE) && iCAUSE_CLEAR;
    assign ev_en    = iEVENT & iEVENT_MASK;
    assign clr_mask = {P_EVENTS{ack_ok}};
    assign pend_d   = (pend_q & ~clr_mask) | ev_en;

    // Events arriving with an accepted ACK land in a freshly cleared pend.
    assign lost_hit = |(ev_en & pend_q & ~clr_mask);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cv_d    = cv_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && !iIRQ_BUSY && !cv_q) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_ok) begin
                    state_d = ST_SERVICE;
                    cause_d = pend_q;
                    cv_d    = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (clr_ok) begin
                    state_d = ST_IDLE;
                    cv_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign prio_d = iPRIORITY_SET_REQ ? iPRIORITY_SET_DATA : prio_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            cause_q <= '0;
            cv_q    <= 1'b0;
            prio_q  <= P_PRIORITY_INIT;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cause_q <= cause_d;
            cv_q    <= cv_d;
            prio_q  <= prio_d;
        end
    end

    gci_sat_counter #(
        .W(LOST_W)
    ) u_lost (
        .clk_i  (iCLOCK),
        .rst_ni (inRESET),
        .inc_i  (lost_hit),
        .cnt_o  (oLOST_COUNT)
    );

    assign oIRQ               = (state_q == ST_REQ);
    assign oCAUSE_VALID       = cv_q;
    assign oCAUSE             = cause_q;
    assign oNODEINFO_PRIORITY = prio_q;

endmodule

// File: tb/tb_gci_node_irq_req.sv
// Directed bench for gci_node_irq_req: per-cycle vector table
// plus hand-written saturation and async-reset sequences.
module tb_gci_node_irq_req;

    logic       iCLOCK;
    logic       inRESET;
    logic [3:0] iEVENT;
    logic [3:0] iEVENT_MASK;
    logic       iPRIORITY_SET_REQ;
    logic [7:0] iPRIORITY_SET_DATA;
    logic [7:0] oNODEINFO_PRIORITY;
    logic       iIRQ_BUSY;
    logic       oIRQ;
    logic       iACK;
    logic       oCAUSE_VALID;
    logic [3:0] oCAUSE;
    logic       iCAUSE_CLEAR;
    logic [7:0] oLOST_COUNT;

    int total = 0;
    int bad   = 0;

    gci_node_irq_req #(
        .P_EVENTS(4),
        .P_PRIORITY_INIT(8'h00)
    ) dut (
        .iCLOCK             (iCLOCK),
        .inRESET            (inRESET),
        .iEVENT             (iEVENT),
        .iEVENT_MASK        (iEVENT_MASK),
        .iPRIORITY_SET_REQ  (iPRIORITY_SET_REQ),
        .iPRIORITY_SET_DATA (iPRIORITY_SET_DATA),
        .oNODEINFO_PRIORITY (oNODEINFO_PRIORITY),
        .iIRQ_BUSY          (iIRQ_BUSY),
        .oIRQ               (oIRQ),
        .iACK               (iACK),
        .oCAUSE_VALID       (oCAUSE_VALID),
        .oCAUSE             (oCAUSE),
        .iCAUSE_CLEAR       (iCAUSE_CLEAR),
        .oLOST_COUNT        (oLOST_COUNT)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [3:0] ev;
        logic [3:0] mask;
        logic       busy;
        logic       ack;
        logic       clr;
        logic       pset;
        logic [7:0] pdata;
        logic       irq;
        logic       cv;
        logic [3:0] cause;
        logic [7:0] lost;
        logic [7:0] prio;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        logic [3:0] ev, logic [3:0] mask, logic busy,
        logic ack, logic clr, logic pset, logic [7:0] pdata,
        logic irq, logic cv, logic [3:0] cause,
        logic [7:0] lost, logic [7:0] prio);
        vec_t v;
        v.ev = ev; v.mask = mask; v.busy = busy;
        v.ack = ack; v.clr = clr; v.pset = pset;
        v.pdata = pdata; v.irq = irq; v.cv = cv;
        v.cause = cause; v.lost = lost; v.prio = prio;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iEVENT             = v.ev;
        iEVENT_MASK        = v.mask;
        iIRQ_BUSY          = v.busy;
        iACK               = v.ack;
        iCAUSE_CLEAR       = v.clr;
        iPRIORITY_SET_REQ  = v.pset;
        iPRIORITY_SET_DATA = v.pdata;
    endtask

    task automatic idle_in();
        iEVENT = 4'h0; iEVENT_MASK = 4'hF; iIRQ_BUSY = 1'b0;
        iACK = 1'b0; iCAUSE_CLEAR = 1'b0;
        iPRIORITY_SET_REQ = 1'b0; iPRIORITY_SET_DATA = 8'h00;
    endtask

    task automatic chk_out(input string tag, input logic irq,
        input logic cv, input logic [3:0] cause,
        input logic [7:0] lost, input logic [7:0] prio);
        chk({tag, ".irq"},   {31'd0, oIRQ},         {31'd0, irq});
        chk({tag, ".cv"},    {31'd0, oCAUSE_VALID}, {31'd0, cv});
        chk({tag, ".cause"}, {28'd0, oCAUSE},       {28'd0, cause});
        chk({tag, ".lost"},  {24'd0, oLOST_COUNT},  {24'd0, lost});
        chk({tag, ".prio"},  {24'd0, oNODEINFO_PRIORITY}, {24'd0, prio});
    endtask

    initial begin
        // ev mask busy ack clr pset pdata | irq cv cause lost prio
        // basic request
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,0,4'h0,8'd0,8'h00));
        vt.push_back(mk(4'h4,4'hF,0,0,0,0,8'h00, 0,0,4'h0,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h0,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h0,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,1,0,0,8'h00, 0,1,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,1,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        // busy gating
        vt.push_back(mk(4'h1,4'hF,1,0,0,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,1,0,0,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,1,0,0,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,1,0,0,8'h00, 0,1,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        // masked event
        vt.push_back(mk(4'h2,4'hD,0,0,0,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        // event colliding with ACK
        vt.push_back(mk(4'h1,4'hF,0,0,0,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h4,4'hF,0,1,0,0,8'h00, 0,1,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,1,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 0,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h1,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,1,0,0,8'h00, 0,1,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        // lost events on bit 3
        vt.push_back(mk(4'h8,4'hF,0,0,0,0,8'h00, 0,0,4'h4,8'd0,8'h00));
        vt.push_back(mk(4'h8,4'hF,0,0,0,0,8'h00, 1,0,4'h4,8'd1,8'h00));
        vt.push_back(mk(4'h8,4'hF,0,0,0,0,8'h00, 1,0,4'h4,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,1,0,0,8'h00, 0,1,4'h8,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 0,0,4'h8,8'd2,8'h00));
        // spurious ACK in IDLE, spurious clear in REQ
        vt.push_back(mk(4'h2,4'hF,1,0,0,0,8'h00, 0,0,4'h8,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,1,1,0,0,8'h00, 0,0,4'h8,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 1,0,4'h8,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,0,1,0,8'h00, 1,0,4'h8,8'd2,8'h00));
        vt.push_back(mk(4'h0,4'hF,0,1,0,0,8'h00, 0,1,4'h2,8'd2,8'h00));
        // priority write while in SERVICE
        vt.push_back(mk(4'h0,4'hF,0,0,0,1,8'h5A, 0,1,4'h2,8'd2,8'h5A));
        vt.push_back(mk(4'h0,4'hF,0,0,0,0,8'h00, 0,1,4'h2,8'd2,8'h5A));

        idle_in();
        inRESET = 1'b0;
        repeat (2) @(posedge iCLOCK);
        #1;
        chk_out("reset", 1'b0, 1'b0, 4'h0, 8'd0, 8'h00);
        inRESET = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i]);
            @(posedge iCLOCK);
            #1;
            chk_out($sformatf("vec%0d", i), vt[i].irq, vt[i].cv,
                    vt[i].cause, vt[i].lost, vt[i].prio);
        end

        // Still in SERVICE: one set plus 300 collisions on bit 0.
        idle_in();
        iEVENT = 4'h1;
        for (int i = 0; i < 301; i++) begin
            @(posedge iCLOCK);
            #1;
            if (i == 10) chk("lost_mid", {24'd0, oLOST_COUNT}, 32'd12);
        end
        chk("lost_sat", {24'd0, oLOST_COUNT}, 32'hFF);
        iEVENT = 4'h0;
        @(posedge iCLOCK);
        #1;
        chk("lost_hold", {24'd0, oLOST_COUNT}, 32'hFF);
        chk("sat_cv", {31'd0, oCAUSE_VALID}, 32'd1);

        // Asynchronous reset mid-cycle while in SERVICE.
        #2;
        inRESET = 1'b0;
        #1;
        chk_out("areset", 1'b0, 1'b0, 4'h0, 8'd0, 8'h00);
        @(posedge iCLOCK);
        #2;
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;
        chk_out("post_reset", 1'b0, 1'b0, 4'h0, 8'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
